// File: rtl/xge_tx_pkt_arbiter.sv
// xge_tx_pkt_arbiter: packet-atomic arbiter sharing the xge_mac pkt_tx_* interface among NUM_REQ requesters.
// Define XGE_TX_ARB_STRICT_PRIO_EN to give requester 0 absolute priority; otherwise pure round-robin.
module xge_tx_pkt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk_156m25,
  input  logic                   reset_156m25_n,
  input  logic [64*NUM_REQ-1:0]  req_tx_data,
  input  logic [3*NUM_REQ-1:0]   req_tx_mod,
  input  logic [NUM_REQ-1:0]     req_tx_sop,
  input  logic [NUM_REQ-1:0]     req_tx_eop,
  input  logic [NUM_REQ-1:0]     req_tx_val,
  output logic [NUM_REQ-1:0]     req_tx_ready,
  output logic [63:0]            pkt_tx_data,
  output logic [2:0]             pkt_tx_mod,
  output logic                   pkt_tx_sop,
  output logic                   pkt_tx_eop,
  output logic                   pkt_tx_val,
  input  logic                   pkt_tx_full,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic                   proto_err
);

  typedef enum logic {IDLE, XFER} state_t;

`ifdef XGE_TX_ARB_STRICT_PRIO_EN
  localparam logic [IDX_W-1:0] RR_BASE = IDX_W'(1);
`else
  localparam logic [IDX_W-1:0] RR_BASE = '0;
`endif

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic               first_word;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] stray;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

  logic [63:0]        g_data;
  logic [2:0]         g_mod;
  logic               g_sop;
  logic               g_eop;
  logic               g_val;
  logic               xfer_go;

  assign eligible = req_tx_val & req_tx_sop;
  assign stray    = req_tx_val & ~req_tx_sop;
  assign busy     = (state == XFER);

  always_comb begin
    g_data = '0;
    g_mod  = '0;
    g_sop  = 1'b0;
    g_eop  = 1'b0;
    g_val  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        g_data = req_tx_data[64*i +: 64];
        g_mod  = req_tx_mod[3*i +: 3];
        g_sop  = req_tx_sop[i];
        g_eop  = req_tx_eop[i];
        g_val  = req_tx_val[i];
      end
    end
  end

  assign xfer_go = (state == XFER) && g_val && !pkt_tx_full;

  // Ready is forced low while reset is held so no requester sees a phantom accept.
  always_comb begin
    req_tx_ready = '0;
    if (reset_156m25_n) begin
      if (state == IDLE) begin
        req_tx_ready = stray;
      end else if (!pkt_tx_full) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_idx == IDX_W'(i)) req_tx_ready[i] = 1'b1;
        end
      end
    end
  end

  // Winner search starts at rr_ptr and wraps; strict mode rotates only over 1..NUM_REQ-1.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = 0;
`ifdef XGE_TX_ARB_STRICT_PRIO_EN
    if (eligible[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
    for (int k = 0; k < NUM_REQ-1; k++) begin
      cand = 1 + ((int'(rr_ptr) - 1 + k) % (NUM_REQ-1));
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
`endif
  end

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    if (int'(g) == NUM_REQ-1) next_ptr = RR_BASE;
    else                      next_ptr = g + 1'b1;
  endfunction

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state       <= IDLE;
      rr_ptr      <= RR_BASE;
      grant_idx   <= '0;
      first_word  <= 1'b0;
      pkt_tx_data <= '0;
      pkt_tx_mod  <= '0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_val  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      pkt_tx_data <= '0;
      pkt_tx_mod  <= '0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_val  <= 1'b0;
      proto_err   <= 1'b0;
      case (state)
        IDLE: begin
          proto_err <= |stray;
          if (win_found) begin
            grant_idx  <= win_idx;
            first_word <= 1'b1;
            state      <= XFER;
          end
        end
        XFER: begin
          if (xfer_go) begin
            pkt_tx_data <= g_data;
            pkt_tx_mod  <= g_mod;
            pkt_tx_sop  <= g_sop;
            pkt_tx_eop  <= g_eop;
            pkt_tx_val  <= 1'b1;
            // The opening sop is expected; any later sop means the previous packet lost its eop.
            proto_err   <= g_sop && !first_word;
            first_word  <= 1'b0;
            if (g_eop) begin
              rr_ptr <= next_ptr(grant_idx);
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xge_tx_pkt_arbiter.sv
// tb_xge_tx_pkt_arbiter: randomized requester/MAC traffic checked against a packet-level reference model.
// Honours XGE_TX_ARB_STRICT_PRIO_EN the same way as the design.
module tb_xge_tx_pkt_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int N_CYC   = 4000;
  localparam int RST_CYC = 1800;

  logic                   clk_156m25 = 1'b0;
  logic                   reset_156m25_n;
  logic [64*NUM_REQ-1:0]  req_tx_data;
  logic [3*NUM_REQ-1:0]   req_tx_mod;
  logic [NUM_REQ-1:0]     req_tx_sop;
  logic [NUM_REQ-1:0]     req_tx_eop;
  logic [NUM_REQ-1:0]     req_tx_val;
  logic [NUM_REQ-1:0]     req_tx_ready;
  logic [63:0]            pkt_tx_data;
  logic [2:0]             pkt_tx_mod;
  logic                   pkt_tx_sop;
  logic                   pkt_tx_eop;
  logic                   pkt_tx_val;
  logic                   pkt_tx_full;
  logic [IDX_W-1:0]       grant_idx;
  logic                   busy;
  logic                   proto_err;

  always #5 clk_156m25 = ~clk_156m25;

  xge_tx_pkt_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk_156m25     (clk_156m25),
    .reset_156m25_n (reset_156m25_n),
    .req_tx_data    (req_tx_data),
    .req_tx_mod     (req_tx_mod),
    .req_tx_sop     (req_tx_sop),
    .req_tx_eop     (req_tx_eop),
    .req_tx_val     (req_tx_val),
    .req_tx_ready   (req_tx_ready),
    .pkt_tx_data    (pkt_tx_data),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_full    (pkt_tx_full),
    .grant_idx      (grant_idx),
    .busy           (busy),
    .proto_err      (proto_err)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
    end
  endtask

  // Requester stimulus state: the word each requester currently offers.
  bit          has_word [NUM_REQ];
  bit          w_stray  [NUM_REQ];
  bit          w_sop    [NUM_REQ];
  bit          w_eop    [NUM_REQ];
  logic [63:0] w_data   [NUM_REQ];
  logic [2:0]  w_mod    [NUM_REQ];
  int          pk_left  [NUM_REQ];
  int          full_left;

  // Reference model: who owns the MAC, where the next search starts, and predicted outputs.
  int                 m_owner;
  int                 m_ptr;
  bit                 m_first;
  logic [IDX_W-1:0]   m_grant;
  logic [NUM_REQ-1:0] exp_ready;
  logic [NUM_REQ-1:0] acc;
  bit                 e_val, e_sop, e_eop, e_err;
  logic [63:0]        e_data;
  logic [2:0]         e_mod;

  function automatic int pickWinner(input logic [NUM_REQ-1:0] elig, input int ptr);
    int order[$];
`ifdef XGE_TX_ARB_STRICT_PRIO_EN
    if (elig[0]) return 0;
    for (int k = 0; k < NUM_REQ-1; k++)
      order.push_back(1 + (((ptr == 0) ? 0 : ptr - 1) + k) % (NUM_REQ-1));
`else
    for (int k = 0; k < NUM_REQ; k++) order.push_back((ptr + k) % NUM_REQ);
`endif
    foreach (order[j]) if (elig[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic int pointerAfter(input int owner);
    int nxt;
    nxt = (owner + 1) % NUM_REQ;
`ifdef XGE_TX_ARB_STRICT_PRIO_EN
    if (nxt == 0) nxt = 1;
`endif
    return nxt;
  endfunction

  task automatic resetModel();
    m_owner = -1;
    m_ptr   = 0;
    m_first = 1'b0;
    m_grant = '0;
    e_val = 0; e_sop = 0; e_eop = 0; e_err = 0; e_data = '0; e_mod = '0;
    acc = '0;
  endtask

  task automatic makeWord(input int i, input bit sop, input bit eop);
    w_data[i]   = {$urandom, $urandom};
    w_mod[i]    = 3'($urandom_range(0, 7));
    w_sop[i]    = sop;
    w_eop[i]    = eop;
    w_stray[i]  = 1'b0;
    has_word[i] = 1'b1;
  endtask

  task automatic startWord(input int i);
    int r, len;
    r = $urandom_range(0, 11);
    if (r == 0) begin
      makeWord(i, 1'b0, 1'($urandom_range(0, 1)));
      w_stray[i] = 1'b1;
      pk_left[i] = 0;
    end else if (r <= 5) begin
      len = $urandom_range(1, 6);
      pk_left[i] = len;
      makeWord(i, 1'b1, len == 1);
    end
  endtask

  task automatic advanceWord(input int i);
    if (w_stray[i] || pk_left[i] <= 1) begin
      has_word[i] = 1'b0;
      pk_left[i]  = 0;
    end else begin
      pk_left[i]--;
      // Occasionally repeat sop inside a packet to exercise the malformed-packet flag.
      makeWord(i, $urandom_range(0, 15) == 0, pk_left[i] == 1);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!has_word[i]) startWord(i);
      req_tx_val[i]          = has_word[i] && (w_stray[i] || $urandom_range(0, 4) != 0);
      req_tx_sop[i]          = w_sop[i];
      req_tx_eop[i]          = w_eop[i];
      req_tx_data[64*i +: 64] = w_data[i];
      req_tx_mod[3*i +: 3]   = w_mod[i];
    end
    if (full_left > 0) begin
      pkt_tx_full = 1'b1;
      full_left--;
    end else begin
      pkt_tx_full = 1'b0;
      if ($urandom_range(0, 7) == 0) full_left = $urandom_range(1, 6);
    end
  endtask

  // Predict this cycle's ready bits and the pkt_tx_* values the next edge must produce.
  task automatic modelStep();
    logic [NUM_REQ-1:0] elig, strays;
    int w;
    elig   = req_tx_val & req_tx_sop;
    strays = req_tx_val & ~req_tx_sop;
    exp_ready = '0;
    e_val = 0; e_sop = 0; e_eop = 0; e_err = 0; e_data = '0; e_mod = '0;
    if (m_owner < 0) begin
      exp_ready = strays;
      e_err     = (strays != '0);
      w = pickWinner(elig, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_first = 1'b1;
        m_grant = IDX_W'(w);
      end
    end else begin
      exp_ready[m_owner] = !pkt_tx_full;
      if (req_tx_val[m_owner] && !pkt_tx_full) begin
        e_val   = 1'b1;
        e_data  = w_data[m_owner];
        e_mod   = w_mod[m_owner];
        e_sop   = w_sop[m_owner];
        e_eop   = w_eop[m_owner];
        e_err   = w_sop[m_owner] && !m_first;
        m_first = 1'b0;
        if (w_eop[m_owner]) begin
          m_ptr   = pointerAfter(m_owner);
          m_owner = -1;
        end
      end
    end
    acc = req_tx_val & exp_ready;
  endtask

  task automatic checkRegistered();
    checkOutput("pkt_tx_val",  64'(pkt_tx_val),  64'(e_val));
    checkOutput("pkt_tx_data", pkt_tx_data,      e_data);
    checkOutput("pkt_tx_mod",  64'(pkt_tx_mod),  64'(e_mod));
    checkOutput("pkt_tx_sop",  64'(pkt_tx_sop),  64'(e_sop));
    checkOutput("pkt_tx_eop",  64'(pkt_tx_eop),  64'(e_eop));
    checkOutput("proto_err",   64'(proto_err),   64'(e_err));
    checkOutput("busy",        64'(busy),        64'(m_owner >= 0));
    checkOutput("grant_idx",   64'(grant_idx),   64'(m_grant));
  endtask

  task automatic clearRequesters();
    for (int i = 0; i < NUM_REQ; i++) begin
      has_word[i] = 1'b0;
      w_stray[i]  = 1'b0;
      w_sop[i]    = 1'b0;
      w_eop[i]    = 1'b0;
      w_data[i]   = '0;
      w_mod[i]    = '0;
      pk_left[i]  = 0;
    end
    full_left = 0;
  endtask

  initial begin
    reset_156m25_n = 1'b0;
    req_tx_data = '0;
    req_tx_mod  = '0;
    req_tx_sop  = '0;
    req_tx_eop  = '0;
    req_tx_val  = '0;
    pkt_tx_full = 1'b0;
    clearRequesters();
    resetModel();

    repeat (3) @(posedge clk_156m25);
    #1;
    checkRegistered();
    checkOutput("reset_ready", 64'(req_tx_ready), 64'(0));
    reset_156m25_n = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      applyStimulus();
      #1;
      modelStep();
      checkOutput("req_tx_ready", 64'(req_tx_ready), 64'(exp_ready));
      @(posedge clk_156m25);
      #1;
      checkRegistered();
      for (int i = 0; i < NUM_REQ; i++) if (acc[i]) advanceWord(i);

      if (cyc == RST_CYC) begin
        // Asynchronous reset in mid-traffic: outputs must collapse before any clock edge.
        reset_156m25_n = 1'b0;
        #1;
        checkOutput("midrst_val",   64'(pkt_tx_val),   64'(0));
        checkOutput("midrst_busy",  64'(busy),         64'(0));
        checkOutput("midrst_ready", 64'(req_tx_ready), 64'(0));
        checkOutput("midrst_grant", 64'(grant_idx),    64'(0));
        repeat (2) @(posedge clk_156m25);
        #1;
        reset_156m25_n = 1'b1;
        clearRequesters();
        resetModel();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
